lif_scheduler: RTL and testbench
================================

# lif_scheduler

Time-multiplexed controller that shares one leaky-integrate-and-fire (LIF) update datapath among `N_NEURONS` virtual neurons. On each timestep `tick` it walks every neuron in index order, applies leak, integration and threshold, and writes the membrane state back. Every spike is presented as a valid/ready event carrying the neuron index. It sits between the tile's input pins (current loading, tick) and the output pins (spike events, state readback).

## Interface
- `N_NEURONS`, 4: number of virtual neurons; power of two, 2..16.
- `WIDTH`, 8: membrane-state and current width, in bits.
- `LEAK_SHIFT`, 2: leak is `state >> LEAK_SHIFT`.
- `REFRACT_STEPS`, 2: timesteps a neuron ignores input after a spike; used only with the refractory macro.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: single-cycle pulse that starts one timestep.
- `threshold` in WIDTH: firing threshold; sampled on tick acceptance and held for the whole timestep.
- `cur_wr_en` in 1: write strobe for a per-neuron input current.
- `cur_wr_addr` in log2(N): index of the neuron whose current is written.
- `cur_wr_data` in WIDTH: current value to write.
- `state_rd_addr` in log2(N): readback address.
- `state_rd_data` out WIDTH: combinational readback of the membrane state at `state_rd_addr`.
- `spike_valid` out 1: a spike event is being presented.
- `spike_id` out log2(N): index of the neuron that spiked.
- `spike_ready` in 1: consumer accepts the spike event.
- `busy` out 1: a timestep is in progress.
- `done` out 1: one-cycle pulse when a timestep completes.
- `tick_overrun` out 1: one-cycle pulse when a tick is ignored.

## Operation
- Storage:
  - Per-neuron current registers; values persist across timesteps and are never cleared by the update.
  - Per-neuron membrane state registers.
- FSM states:
  - IDLE: `tick` → UPDATE; index = 0; threshold latched.
  - UPDATE: one neuron per cycle. No spike → index+1, or DONE after the last neuron. Spike → EMIT.
  - EMIT: `spike_valid` = 1 and `spike_id` = index, held stable until `spike_ready`. On handshake → next index in UPDATE, or DONE after the last neuron.
  - DONE: `done` = 1 for one cycle → IDLE.
- Update arithmetic, in WIDTH+1 bits:
  - `sum = state - (state >> LEAK_SHIFT) + current`.
  - `next = min(sum, 2^WIDTH - 1)`, i.e. the sum saturates, never wraps.
  - `next >= threshold` → spike, and state is written to 0. Otherwise state is written to `next`.
  - `threshold` = 0 → every neuron spikes every step.
  - State is written in the UPDATE cycle, before EMIT.
- Current write in the same cycle the neuron is being updated: the update uses the old value, and the new value is stored for the next timestep.
- `tick` while `busy` → ignored; `tick_overrun` pulses.

## Timing
- Reset values:
  - All outputs 0.
  - All states and currents 0.
  - FSM in IDLE.
- Reset mid-timestep aborts immediately: no `done`, and a pending spike is dropped.
- `busy` is high from the cycle after tick acceptance through the DONE cycle.
- Latency with no spikes: `done` is asserted N+1 cycles after the tick edge.
- Each spike adds 1 cycle plus any stall cycles spent waiting for `spike_ready`.
- `spike_ready` held high: each spike costs exactly one extra cycle.
- `state_rd_data` reflects a write on the cycle after that write.

## Configuration
- `LIF_REFRACTORY_EN` defined:
  - Each neuron has a refractory down-counter of width log2(REFRACT_STEPS+1).
  - A spike loads the counter with `REFRACT_STEPS`.
  - While the counter is nonzero, the update writes state 0, emits no spike, and decrements the counter.
- `LIF_REFRACTORY_EN` not defined: no counters exist, and integration resumes on the very next timestep.

## Structure
- Shared package `lif_pkg`:
  - FSM state enum (IDLE/UPDATE/EMIT/DONE).
  - Default `WIDTH`/`LEAK_SHIFT` constants.
  - Saturating-add helper function.
- Sub-module `lif_update`: combinational state/current/threshold → next_state and spike. It is reused by any future single-neuron tile.
- `lif_scheduler` holds the FSM, the register files and the handshake logic.

## Test plan
- Neuron 0 with current 100, threshold 200, spike_ready tied high:
  - Step 1 state → 100, step 2 → 175.
  - Step 3: spike with `spike_id` = 0 and state → 0.
- Threshold 255, neuron 1 with current 200:
  - Step 1 → 200.
  - Step 2: sum 350 saturates to 255, spike, state → 0.
- Neurons 0 and 2 both spike in one step with `spike_ready` low for 3 cycles on the first spike:
  - `spike_id` 0 is held stable for the stall.
  - Then `spike_id` 2 is presented.
  - `done` arrives N+1+2+3 cycles after tick.
- Second `tick` 2 cycles after the first → `tick_overrun` pulses once and exactly one `done` is produced.
- `rst` asserted in EMIT → `spike_valid`, `busy` and all states are 0 immediately; the next tick runs normally from zero.
- With `LIF_REFRACTORY_EN`, current 255 on neuron 3, threshold 100, REFRACT_STEPS 2:
  - Spike on step 1.
  - State 0 with no spike on steps 2–3.
  - Spike again on step 4.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron scheduler and update datapath.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } lif_state_e;

    localparam int unsigned LIF_DEFAULT_WIDTH      = 8;
    localparam int unsigned LIF_DEFAULT_LEAK_SHIFT = 2;
    localparam int unsigned LIF_MAX_W              = 32;

    // Unsigned add clamped to 2^width - 1; operands are zero-extended by the caller.
    function automatic logic [LIF_MAX_W-1:0] lif_sat_add(
        input logic [LIF_MAX_W-1:0] a,
        input logic [LIF_MAX_W-1:0] b,
        input int unsigned          width
    );
        logic [LIF_MAX_W:0] sum;
        logic [LIF_MAX_W:0] limit;
        sum   = {1'b0, a} + {1'b0, b};
        limit = ((LIF_MAX_W+1)'(1) << width) - (LIF_MAX_W+1)'(1);
        return (sum > limit) ? limit[LIF_MAX_W-1:0] : sum[LIF_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lif_scheduler_if.sv
// Tile-side bundle of the LIF scheduler: tick/current loading, spike events, state readback.
interface lif_scheduler_if #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned WIDTH     = 8
);
    localparam int unsigned IW = $clog2(N_NEURONS);

    logic             tick;
    logic [WIDTH-1:0] threshold;
    logic             cur_wr_en;
    logic [IW-1:0]    cur_wr_addr;
    logic [WIDTH-1:0] cur_wr_data;
    logic [IW-1:0]    state_rd_addr;
    logic [WIDTH-1:0] state_rd_data;
    logic             spike_valid;
    logic [IW-1:0]    spike_id;
    logic             spike_ready;
    logic             busy;
    logic             done;
    logic             tick_overrun;

    modport master (
        output tick, threshold, cur_wr_en, cur_wr_addr, cur_wr_data,
               state_rd_addr, spike_ready,
        input  state_rd_data, spike_valid, spike_id, busy, done, tick_overrun
    );

    modport slave (
        input  tick, threshold, cur_wr_en, cur_wr_addr, cur_wr_data,
               state_rd_addr, spike_ready,
        output state_rd_data, spike_valid, spike_id, busy, done, tick_overrun
    );

endinterface

// File: rtl/lif_update.sv
// Single-neuron LIF step: leak, saturating integration, threshold and reset-to-zero.
module lif_update
    import lif_pkg::*;
#(
    parameter int unsigned WIDTH      = LIF_DEFAULT_WIDTH,
    parameter int unsigned LEAK_SHIFT = LIF_DEFAULT_LEAK_SHIFT
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic [WIDTH-1:0] i_current,
    input  logic [WIDTH-1:0] i_threshold,
    output logic [WIDTH-1:0] o_next_state,
    output logic             o_spike
);

    logic [WIDTH-1:0] w_leaked;
    logic [WIDTH-1:0] w_sat;

    assign w_leaked     = i_state - (i_state >> LEAK_SHIFT);
    assign w_sat        = WIDTH'(lif_sat_add(LIF_MAX_W'(w_leaked), LIF_MAX_W'(i_current), WIDTH));
    assign o_spike      = (w_sat >= i_threshold);
    assign o_next_state = o_spike ? '0 : w_sat;

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF controller: walks N virtual neurons per tick through one lif_update.
// Optional refractory counters are built when LIF_REFRACTORY_EN is defined.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int unsigned N_NEURONS     = 4,
    parameter int unsigned WIDTH         = LIF_DEFAULT_WIDTH,
    parameter int unsigned LEAK_SHIFT    = LIF_DEFAULT_LEAK_SHIFT,
    parameter int unsigned REFRACT_STEPS = 2
) (
    input logic            clk,
    input logic            rst,
    lif_scheduler_if.slave bus
);

    localparam int unsigned   IW       = $clog2(N_NEURONS);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

    lif_state_e       r_fsm;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_thr;
    logic             r_overrun;
    logic [WIDTH-1:0] r_cur [N_NEURONS];
    logic [WIDTH-1:0] r_mem [N_NEURONS];

    logic [WIDTH-1:0] w_next;
    logic             w_fire;
    logic             w_refr_active;
    logic             w_spike;
    logic [WIDTH-1:0] w_wr_state;
    logic             w_last;

    lif_update #(
        .WIDTH      (WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .i_state      (r_mem[r_idx]),
        .i_current    (r_cur[r_idx]),
        .i_threshold  (r_thr),
        .o_next_state (w_next),
        .o_spike      (w_fire)
    );

`ifdef LIF_REFRACTORY_EN
    localparam int unsigned RW = $clog2(REFRACT_STEPS + 1);
    logic [RW-1:0] r_refr [N_NEURONS];

    assign w_refr_active = (r_refr[r_idx] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) r_refr[i] <= '0;
        end else if (r_fsm == ST_UPDATE) begin
            if (w_refr_active)
                r_refr[r_idx] <= r_refr[r_idx] - RW'(1);
            else if (w_fire)
                r_refr[r_idx] <= RW'(REFRACT_STEPS);
        end
    end
`else
    assign w_refr_active = 1'b0;
`endif

    assign w_spike    = w_fire && !w_refr_active;
    assign w_wr_state = w_refr_active ? '0 : w_next;
    assign w_last     = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm     <= ST_IDLE;
            r_idx     <= '0;
            r_thr     <= '0;
            r_overrun <= 1'b0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                r_cur[i] <= '0;
                r_mem[i] <= '0;
            end
        end else begin
            r_overrun <= bus.tick && (r_fsm != ST_IDLE);
            // Current writes land independently; the datapath reads the pre-write value this cycle.
            if (bus.cur_wr_en) r_cur[bus.cur_wr_addr] <= bus.cur_wr_data;

            case (r_fsm)
                ST_IDLE: begin
                    if (bus.tick) begin
                        r_fsm <= ST_UPDATE;
                        r_idx <= '0;
                        r_thr <= bus.threshold;
                    end
                end
                ST_UPDATE: begin
                    r_mem[r_idx] <= w_wr_state;
                    if (w_spike)     r_fsm <= ST_EMIT;
                    else if (w_last) r_fsm <= ST_DONE;
                    else             r_idx <= r_idx + IW'(1);
                end
                ST_EMIT: begin
                    if (bus.spike_ready) begin
                        if (w_last) begin
                            r_fsm <= ST_DONE;
                        end else begin
                            r_fsm <= ST_UPDATE;
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy          = (r_fsm != ST_IDLE);
    assign bus.done          = (r_fsm == ST_DONE);
    assign bus.spike_valid   = (r_fsm == ST_EMIT);
    assign bus.spike_id      = r_idx;
    assign bus.tick_overrun  = r_overrun;
    assign bus.state_rd_data = r_mem[bus.state_rd_addr];

endmodule

// File: tb/tb_lif_scheduler.sv
// Scoreboard bench for lif_scheduler: a reference model queues expected spike ids per tick.
module tb_lif_scheduler;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned LS  = 2;
    localparam int unsigned REF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lif_scheduler_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    lif_scheduler #(
        .N_NEURONS     (N),
        .WIDTH         (W),
        .LEAK_SHIFT    (LS),
        .REFRACT_STEPS (REF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_done   = 0;
    int unsigned n_ovr    = 0;
    int unsigned n_spk    = 0;
    int unsigned q_spk [$];

    int unsigned m_state [N];
    int unsigned m_cur   [N];
    int unsigned m_ref   [N];
    int unsigned m_thr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0;
            m_cur[i]   = 0;
            m_ref[i]   = 0;
        end
        q_spk.delete();
    endtask

    // One timestep of the reference model; queues the spike ids the DUT must emit, in order.
    task automatic model_step();
        int unsigned s;
        for (int i = 0; i < N; i++) begin
            s = m_state[i] - (m_state[i] >> LS) + m_cur[i];
            if (s > 255) s = 255;
`ifdef LIF_REFRACTORY_EN
            if (m_ref[i] != 0) begin
                m_ref[i]--;
                m_state[i] = 0;
                continue;
            end
`endif
            if (s >= m_thr) begin
                q_spk.push_back(i);
                m_state[i] = 0;
                m_ref[i]   = REF;
            end else begin
                m_state[i] = s;
            end
        end
    endtask

    task automatic write_cur(input int unsigned idx, input int unsigned val);
        @(negedge clk);
        bus.cur_wr_en   = 1'b1;
        bus.cur_wr_addr = 2'(idx);
        bus.cur_wr_data = 8'(val);
        @(posedge clk);
        #1 bus.cur_wr_en = 1'b0;
        m_cur[idx] = val;
    endtask

    task automatic rd_check(input string tag, input int unsigned idx, input int unsigned exp);
        bus.state_rd_addr = 2'(idx);
        #1 check(tag, 32'(bus.state_rd_data), exp);
    endtask

    task automatic model_compare();
        for (int i = 0; i < N; i++) rd_check("state_vs_model", i, m_state[i]);
    endtask

    // Latency is counted with the cycle that starts at the tick-accepting edge as cycle 1.
    task automatic do_step(input string tag, input int unsigned thr, input int unsigned exp_lat);
        int unsigned lat;
        m_thr = thr;
        model_step();
        @(negedge clk);
        bus.threshold = 8'(thr);
        bus.tick      = 1'b1;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        if (exp_lat != 0) check(tag, lat, exp_lat);
        else              check({tag, "_timeout"}, 32'(lat < 200), 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every spike handshake and checks id stability under stall.
    initial begin
        logic        held;
        int unsigned held_id;
        held = 1'b0;
        held_id = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (bus.done)         n_done++;
                if (bus.tick_overrun) n_ovr++;
                if (bus.spike_valid) begin
                    if (held) check("spike_hold", 32'(bus.spike_id), held_id);
                    if (bus.spike_ready) begin
                        n_spk++;
                        held = 1'b0;
                        if (q_spk.size() == 0) check("spike_unexpected", 32'(bus.spike_id), 99);
                        else                   check("spike_id", 32'(bus.spike_id), q_spk.pop_front());
                    end else begin
                        held    = 1'b1;
                        held_id = 32'(bus.spike_id);
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        int unsigned k;
        int unsigned d0;
        int unsigned o0;
        int unsigned s0;

        bus.tick          = 1'b0;
        bus.threshold     = '0;
        bus.cur_wr_en     = 1'b0;
        bus.cur_wr_addr   = '0;
        bus.cur_wr_data   = '0;
        bus.state_rd_addr = '0;
        bus.spike_ready   = 1'b1;
        model_reset();

        #12;
        check("rst_spike_valid", 32'(bus.spike_valid), 0);
        check("rst_spike_id", 32'(bus.spike_id), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_overrun", 32'(bus.tick_overrun), 0);
        for (int i = 0; i < N; i++) rd_check("rst_state", i, 0);
        @(negedge clk);
        rst = 1'b0;

        // Neuron 0 climbs 100 -> 175 -> spike
        write_cur(0, 100);
        do_step("lat_nospike", 200, N + 1);
        rd_check("t1_s1", 0, 100);
        do_step("lat_s2", 200, N + 1);
        rd_check("t1_s2", 0, 175);
        s0 = n_spk;
        do_step("lat_spike", 200, N + 2);
        rd_check("t1_s3", 0, 0);
        check("t1_spikes", n_spk - s0, 1);

        // Saturation: 200 - 50 + 200 clamps to 255, which meets threshold 255
        write_cur(0, 0);
        write_cur(1, 200);
        do_step("lat_t2a", 255, N + 1);
        rd_check("t2_s1", 1, 200);
        do_step("lat_t2b", 255, N + 2);
        rd_check("t2_s2", 1, 0);

        // Two spikes in one step, first one stalled three cycles
        write_cur(0, 50);
        write_cur(1, 10);
        write_cur(2, 60);
        write_cur(3, 10);
        bus.spike_ready = 1'b0;
        fork
            do_step("lat_stall", 40, N + 1 + 2 + 3);
            begin
                k = 0;
                while (!bus.spike_valid && k < 50) begin
                    @(posedge clk);
                    #1 k++;
                end
                check("stall_saw_valid", 32'(bus.spike_valid), 1);
                check("stall_first_id", 32'(bus.spike_id), 0);
                repeat (3) @(posedge clk);
                #1 bus.spike_ready = 1'b1;
            end
        join
        model_compare();

        // Overrun: second tick two cycles after the first
        d0 = n_done;
        o0 = n_ovr;
        m_thr = 40;
        model_step();
        @(negedge clk);
        bus.threshold = 8'd40;
        bus.tick      = 1'b1;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        @(negedge clk);
        bus.tick = 1'b1;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        check("overrun_pulse", 32'(bus.tick_overrun), 1);
        @(posedge clk);
        #1 check("overrun_clear", 32'(bus.tick_overrun), 0);
        repeat (30) @(posedge clk);
        #1;
        check("overrun_done_cnt", n_done - d0, 1);
        check("overrun_ovr_cnt", n_ovr - o0, 1);
        model_compare();

        // Reset while a spike is pending
        for (int i = 0; i < N; i++) write_cur(i, 200);
        bus.spike_ready = 1'b0;
        @(negedge clk);
        bus.threshold = 8'd40;
        bus.tick      = 1'b1;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        k = 0;
        while (!bus.spike_valid && k < 50) begin
            @(posedge clk);
            #1 k++;
        end
        check("emit_reached", 32'(bus.spike_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 32'(bus.spike_valid), 0);
        check("abort_busy", 32'(bus.busy), 0);
        for (int i = 0; i < N; i++) rd_check("abort_state", i, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.spike_ready = 1'b1;
        write_cur(0, 100);
        do_step("lat_after_rst", 200, N + 1);
        rd_check("after_rst_s0", 0, 100);

`ifdef LIF_REFRACTORY_EN
        // Refractory: spike, two silent steps, spike again
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        write_cur(3, 255);
        s0 = n_spk;
        do_step("ref_lat1", 100, 0);
        check("ref_spk1", n_spk - s0, 1);
        rd_check("ref_s1", 3, 0);
        s0 = n_spk;
        do_step("ref_lat2", 100, N + 1);
        check("ref_spk2", n_spk - s0, 0);
        rd_check("ref_s2", 3, 0);
        s0 = n_spk;
        do_step("ref_lat3", 100, N + 1);
        check("ref_spk3", n_spk - s0, 0);
        rd_check("ref_s3", 3, 0);
        s0 = n_spk;
        do_step("ref_lat4", 100, 0);
        check("ref_spk4", n_spk - s0, 1);
`endif

        repeat (2) @(posedge clk);
        #1 check("spikes_outstanding", q_spk.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1);
    end

endmodule
